// File: rtl/sram_port_arbiter_pkg.sv
// rtl/sram_port_arbiter_pkg.sv - shared constants, types and helpers for the SRAM port arbiter
package sram_port_arbiter_pkg;

    localparam int PerfCntW  = 16;
    localparam int MaxNumReq = 4;

    typedef logic [1:0] req_id_t;

    // Expand a requester ID into a one-hot vector over the maximum requester count
    function automatic logic [MaxNumReq-1:0] onehot_id(input req_id_t id);
        logic [MaxNumReq-1:0] oh;
        oh     = '0;
        oh[id] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// rtl/sram_port_arbiter_if.sv - requester-side and SRAM-side bus bundle for the SRAM port arbiter
interface sram_port_arbiter_if #(
    parameter int NumReq = 2,
    parameter int SramAw = 14,
    parameter int SramDw = 32
);
    localparam int MaskW = SramDw / 8;

    // Requester side
    logic [NumReq-1:0]             req;
    logic [NumReq-1:0]             we;
    logic [NumReq-1:0][SramAw-1:0] addr;
    logic [NumReq-1:0][SramDw-1:0] wdata;
    logic [NumReq-1:0][MaskW-1:0]  wmask;
    logic [NumReq-1:0]             gnt;
    logic [NumReq-1:0]             rvalid;
    logic [SramDw-1:0]             rdata;
    logic [1:0]                    rerror;

    // SRAM side
    logic                          sram_req;
    logic                          sram_we;
    logic [SramAw-1:0]             sram_addr;
    logic [SramDw-1:0]             sram_wdata;
    logic [MaskW-1:0]              sram_wmask;
    logic                          sram_gnt;
    logic                          sram_rvalid;
    logic [SramDw-1:0]             sram_rdata;
    logic [1:0]                    sram_rerror;

    // Arbiter view
    modport slave (
        input  req, we, addr, wdata, wmask, sram_gnt, sram_rvalid, sram_rdata, sram_rerror,
        output gnt, rvalid, rdata, rerror, sram_req, sram_we, sram_addr, sram_wdata, sram_wmask
    );

    // Environment view (requesters plus SRAM)
    modport master (
        output req, we, addr, wdata, wmask, sram_gnt, sram_rvalid, sram_rdata, sram_rerror,
        input  gnt, rvalid, rdata, rerror, sram_req, sram_we, sram_addr, sram_wdata, sram_wmask
    );

endinterface

// File: rtl/sram_port_arbiter_id_fifo.sv
// rtl/sram_port_arbiter_id_fifo.sv - in-order requester-ID FIFO tracking reads in flight
module sram_arb_id_fifo #(
    parameter int Depth = 2,
    parameter int Width = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] wdata_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             pop_err_o
);
    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    assign full_o    = (cnt_q == CntW'(Depth));
    assign empty_o   = (cnt_q == '0);
    assign push_ok   = push_i & ~full_o;
    assign pop_ok    = pop_i & ~empty_o;
    assign pop_err_o = pop_i & empty_o;
    assign rdata_o   = mem_q[rd_q];

    // Pointer wrap and occupancy update; push and pop together leave occupancy unchanged
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push_ok) begin
            wr_d = (wr_q == PtrW'(Depth - 1)) ? '0 : wr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_d = (rd_q == PtrW'(Depth - 1)) ? '0 : rd_q + 1'b1;
        end
        if (push_ok && !pop_ok) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Pointer and occupancy registers, reset to empty
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only read when the occupancy says they are valid
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - round-robin SRAM port arbiter with in-order read routing; SRAM_PORT_ARBITER_PERF_EN adds perf counters
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int NumReq         = 2,
    parameter int SramAw         = 14,
    parameter int SramDw         = 32,
    parameter int MaxOutstanding = 2
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    sram_port_arbiter_if.slave               bus,
`ifdef SRAM_PORT_ARBITER_PERF_EN
    input  logic                             perf_clr_i,
    output logic [NumReq-1:0][PerfCntW-1:0]  perf_grant_cnt_o,
    output logic [NumReq-1:0][PerfCntW-1:0]  perf_stall_cnt_o,
`endif
    output logic                             rsp_err_o
);
    localparam int MaskW = SramDw / 8;

    logic [NumReq-1:0]    req_eff, eligible, gnt;
    logic [MaxNumReq-1:0] win_oh, head_oh;
    req_id_t              win_id, rr_q, rr_d, head_id;
    logic                 win_found, win_we, hs;
    logic                 fifo_full, fifo_empty, fifo_push, fifo_pop, pop_err;
    logic                 rsp_err_q, rsp_err_d;

    // Requests are ignored while reset is asserted so every output reads 0
    assign req_eff  = rst_ni ? bus.req : '0;
    // A full ID FIFO blocks reads only; it is not bypassed by a same-cycle pop
    assign eligible = req_eff & (bus.we | {NumReq{~fifo_full}});

    // Round-robin search over eligible requesters starting at rr_q
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int off = 0; off < NumReq; off++) begin
            for (int i = 0; i < NumReq; i++) begin
                if (!win_found && eligible[i] && ((int'(rr_q) + off) % NumReq == i)) begin
                    win_found = 1'b1;
                    win_id    = req_id_t'(i);
                end
            end
        end
    end

    // Winner payload onto the SRAM port; all zero when nobody is eligible
    always_comb begin
        win_we         = 1'b0;
        bus.sram_addr  = '0;
        bus.sram_wdata = '0;
        bus.sram_wmask = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (win_found && win_id == req_id_t'(i)) begin
                win_we         = bus.we[i];
                bus.sram_addr  = bus.addr[i];
                bus.sram_wdata = bus.wdata[i];
                bus.sram_wmask = bus.wmask[i];
            end
        end
    end

    assign win_oh       = onehot_id(win_id);
    assign hs           = win_found & bus.sram_gnt;
    assign gnt          = win_oh[NumReq-1:0] & {NumReq{hs}};
    assign bus.gnt      = gnt;
    assign bus.sram_req = win_found;
    assign bus.sram_we  = win_we;

    assign fifo_push = hs & ~win_we;
    assign fifo_pop  = bus.sram_rvalid & rst_ni;

    sram_arb_id_fifo #(
        .Depth (MaxOutstanding),
        .Width ($bits(req_id_t))
    ) u_id_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push_i    (fifo_push),
        .pop_i     (fifo_pop),
        .wdata_i   (win_id),
        .rdata_o   (head_id),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .pop_err_o (pop_err)
    );

    // Responses pass straight through to the requester at the head of the ID FIFO
    assign head_oh     = onehot_id(head_id);
    assign bus.rvalid  = (fifo_pop && !fifo_empty) ? head_oh[NumReq-1:0] : '0;
    assign bus.rdata   = rst_ni ? bus.sram_rdata : '0;
    assign bus.rerror  = rst_ni ? bus.sram_rerror : 2'b00;
    assign rsp_err_o   = rsp_err_q;

    // Next pointer follows the last winner; a stalled winner keeps its priority
    always_comb begin
        rr_d      = rr_q;
        rsp_err_d = rsp_err_q | pop_err;
        if (hs) begin
            rr_d = (int'(win_id) == NumReq - 1) ? '0 : win_id + 1'b1;
        end
    end

    // Round-robin pointer and sticky protocol-error flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q      <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            rr_q      <= rr_d;
            rsp_err_q <= rsp_err_d;
        end
    end

`ifdef SRAM_PORT_ARBITER_PERF_EN
    logic [NumReq-1:0][PerfCntW-1:0] pg_q, pg_d, ps_q, ps_d;

    // Saturating grant/stall counters; clear wins over increment
    always_comb begin
        pg_d = pg_q;
        ps_d = ps_q;
        for (int i = 0; i < NumReq; i++) begin
            if (perf_clr_i) begin
                pg_d[i] = '0;
                ps_d[i] = '0;
            end else begin
                if (gnt[i] && pg_q[i] != '1) begin
                    pg_d[i] = pg_q[i] + 1'b1;
                end
                if (req_eff[i] && !gnt[i] && ps_q[i] != '1) begin
                    ps_d[i] = ps_q[i] + 1'b1;
                end
            end
        end
    end

    // Perf counter registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pg_q <= '0;
            ps_q <= '0;
        end else begin
            pg_q <= pg_d;
            ps_q <= ps_d;
        end
    end

    assign perf_grant_cnt_o = pg_q;
    assign perf_stall_cnt_o = ps_q;
`else
    logic unused_mask_w;
    assign unused_mask_w = (MaskW == 0);
`endif

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one single-ported SRAM request port (req/gnt/we/addr/wdata/wmask, rvalid/rdata/rerror) among NumReq requesters, e.g. the TL-UL SRAM adapter and the boot-image hash/copy engine.
- Arbitration is round-robin, one grant per cycle.
- Read responses return in order; each one is routed back to the requester that issued the read, using an in-order ID FIFO.
- Sits between the requester-side adapters and the SRAM model/macro in the secure-boot SRAM subsystem.

Parameters:
- NumReq, 2, number of requesters (2..4).
- SramAw, 14, SRAM word-address width.
- SramDw, 32, SRAM data width; the mask is SramDw/8 bits.
- MaxOutstanding, 2, maximum number of reads in flight; this is the ID FIFO depth (power of two, 1..8).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_i  in  NumReq  per-requester request.
- we_i  in  NumReq  per-requester write enable.
- addr_i  in  NumReq x SramAw  word addresses.
- wdata_i  in  NumReq x SramDw  write data.
- wmask_i  in  NumReq x SramDw/8  byte masks.
- gnt_o  out  NumReq  one-hot grant.
- rvalid_o  out  NumReq  one-hot read-response valid.
- rdata_o  out  SramDw  read data, broadcast to all requesters.
- rerror_o  out  2  read error, broadcast to all requesters.
- sram_req_o  out  1  SRAM request.
- sram_we_o  out  1  SRAM write enable.
- sram_addr_o  out  SramAw  SRAM word address.
- sram_wdata_o  out  SramDw  SRAM write data.
- sram_wmask_o  out  SramDw/8  SRAM byte mask.
- sram_gnt_i  in  1  SRAM accepts the request.
- sram_rvalid_i  in  1  SRAM read response valid.
- sram_rdata_i  in  SramDw  SRAM read data.
- sram_rerror_i  in  2  SRAM read error.
- rsp_err_o  out  1  sticky protocol error.

Behaviour:
- Clocking and reset:
  - Single clock; reset is asynchronous active-low on rst_ni.
  - Reset values: rr_ptr=0, ID FIFO empty, rsp_err_o=0.
  - All outputs are 0 during reset, because no req_i is considered while rst_ni=0.
- Eligibility: requester i is eligible when req_i[i]=1 and it may issue, where may-issue means we_i[i]=1 OR fifo_full=0.
  - Writes are never blocked by the FIFO.
- Selection and SRAM request (combinational):
  - Selection is round-robin starting at rr_ptr, over eligible requesters.
  - sram_req_o=1 when any requester is eligible; the winner's we/addr/wdata/wmask are muxed onto the SRAM port.
  - With no winner, sram_we/addr/wdata/wmask are 0.
- Grant:
  - gnt_o[i] = winner[i] & sram_gnt_i, so a grant takes 0 cycles.
  - Requesters hold req and payload stable until granted.
- On a handshake (sram_req_o & sram_gnt_i):
  - rr_ptr <= (winner+1) mod NumReq.
  - If the access is a read, push the winner ID into the FIFO.
  - Without a handshake, rr_ptr holds, so the winner keeps priority.
- Read response:
  - sram_rvalid_i pops the FIFO head ID h.
  - Same cycle: rvalid_o = onehot(h); rdata_o = sram_rdata_i; rerror_o = sram_rerror_i.
  - Arbiter response latency is 0 cycles combinational pass-through; end-to-end latency equals the SRAM latency.
- Writes produce no response.
- Simultaneous push and pop:
  - Allowed; occupancy is unchanged.
  - When the FIFO is full, a read is not eligible even if a pop happens in the same cycle. This is a deliberate no-bypass rule that keeps timing short.
- Protocol error: sram_rvalid_i while the FIFO is empty sets rsp_err_o (sticky until reset); rvalid_o stays 0 and the response is dropped.
- Reset mid-operation: the FIFO is cleared and any in-flight read responses are discarded.
- Boundaries:
  - NumReq=1 degenerates to pass-through with the FIFO.
  - rr_ptr wraps from NumReq-1 to 0.
  - Occupancy counts 0..MaxOutstanding inclusive using a $clog2(MaxOutstanding+1)-bit counter.

Optional Feature:
- Macro SRAM_PORT_ARBITER_PERF_EN.
- Defined:
  - Adds output perf_grant_cnt_o (NumReq x 16) and output perf_stall_cnt_o (NumReq x 16).
  - The grant counter increments on gnt_o[i].
  - The stall counter increments when req_i[i]=1 and gnt_o[i]=0.
  - Both counters saturate at 16'hFFFF and reset to 0.
  - Adds input perf_clr_i (1): synchronous clear, which wins over increment.
- Undefined: the perf ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package sram_port_arbiter_pkg holds:
  - PerfCntW=16.
  - MaxNumReq=4.
  - typedef req_id_t (logic [1:0]).
  - function onehot_id.
- Sub-module sram_arb_id_fifo:
  - Parameters: Depth, Width.
  - Ports: push, pop, wdata, rdata, full, empty.
  - Asynchronous reset to empty.
  - Pop on empty is ignored and flagged to the parent.

Test Plan:
- Single requester: req0 read at addr 0x010, then SRAM rvalid with rdata 0xDEADBEEF → gnt_o=01 in the request cycle; rvalid_o=01 and rdata_o=0xDEADBEEF when the SRAM responds.
- Fairness: both requesters issue continuous reads with sram_gnt_i=1 and the SRAM responding → grants alternate 01,10,01,10; responses are routed in issue order; 8 grants total, 4 each.
- Backpressure: sram_gnt_i=0 for 3 cycles with req0 and req1 both asserted, rr_ptr=1 → no grant during the stall; when sram_gnt_i returns, the first grant goes to 10 (req1), then 01.
- FIFO full (MaxOutstanding=2): two reads issued with no rvalid, then a third read and a write are requested → the third read is held (gnt=0) while the write is granted; after one rvalid pop the third read is granted on the next cycle.
- Spurious rvalid: sram_rvalid_i with the FIFO empty → rsp_err_o goes to 1 and stays 1; rvalid_o=0.
- Reset mid-operation: assert rst_ni=0 with 2 reads outstanding → FIFO empty, rsp_err_o=0; a subsequent stale rvalid sets rsp_err_o. With SRAM_PORT_ARBITER_PERF_EN, the perf counters read 0 after reset and after perf_clr_i.
